// File: rtl/rf_multiport.sv
// Multi-read-port register file with byte-enabled writes, write-through bypass and a
// self-timed clear sweep that runs after reset or on request before writes are accepted.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_req,
    output logic                         ready,
    input  logic                         w_ena,
    input  logic [ADDR_W-1:0]            w_addr,
    input  logic [DATA_W-1:0]            w_data,
    input  logic [DATA_W/8-1:0]          w_be,
    input  logic [RD_PORTS*ADDR_W-1:0]   r_addr,
    output logic [RD_PORTS*DATA_W-1:0]   r_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            clr_cnt_q, clr_cnt_d;
    logic                         ready_q, ready_d;
    logic [RD_PORTS*DATA_W-1:0]   r_data_q, r_data_d;

    logic [DATA_W-1:0]            mem_q [DEPTH];

    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_waddr;
    logic [DATA_W-1:0]            mem_wdata;
    logic [NB-1:0]                mem_wbe;
    logic                         wr_acc;
    logic                         rd_live;
    logic [ADDR_W-1:0]            rd_addr;
    logic [DATA_W-1:0]            rd_word;

    // The sweep reuses the normal write port: full-width zero write to entry clr_cnt.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        mem_we    = 1'b0;
        mem_waddr = w_addr;
        mem_wdata = w_data;
        mem_wbe   = w_be;
        wr_acc    = 1'b0;
        rd_live   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    ready_d   = 1'b0;
                end else begin
                    rd_live = 1'b1;
                    wr_acc  = w_ena;
                    mem_we  = w_ena && !((ZERO_REG != 0) && (w_addr == '0));
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Bypass merges the accepted write over the pre-write word; the zero-register rule wins.
    always_comb begin
        r_data_d = '0;
        rd_addr  = '0;
        rd_word  = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_addr = r_addr[p*ADDR_W +: ADDR_W];
            rd_word = mem_q[rd_addr];
            if (wr_acc && (rd_addr == w_addr)) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_be[b]) begin
                        rd_word[8*b +: 8] = w_data[8*b +: 8];
                    end
                end
            end
            if (!rd_live || ((ZERO_REG != 0) && (rd_addr == '0))) begin
                rd_word = '0;
            end
            r_data_d[p*DATA_W +: DATA_W] = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            r_data_q  <= r_data_d;
        end
    end

    // Storage has no reset; the sweep is what gives it a defined value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready  = ready_q;
    assign r_data = r_data_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: directed vector table on a default instance, directed zero-register
// and reset sequences, then random traffic on two configurations against a reference model.
module tb_rf_multiport;

    typedef struct packed {
        logic            w_ena;
        logic [7:0]      w_addr;
        logic [63:0]     w_data;
        logic [7:0]      w_be;
        logic            clr;
        logic [3:0][7:0] r_addr;
    } stim_t;

    typedef struct packed {
        logic        w_ena;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        logic [3:0]  w_be;
        logic        clr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        exp_ready;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        clr0, wena0, ready0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic [3:0]  wbe0;
    logic [9:0]  raddr0;
    logic [63:0] rdata0;

    logic        clr1, wena1, ready1;
    logic [1:0]  waddr1;
    logic [7:0]  wdata1;
    logic [0:0]  wbe1;
    logic [7:0]  raddr1;
    logic [31:0] rdata1;

    int checks = 0;
    int failures = 0;

    int m_depth [2] = '{32, 4};
    int m_dw    [2] = '{32, 8};
    int m_np    [2] = '{2, 4};
    int m_zr    [2] = '{1, 0};
    int m_nb    [2] = '{4, 1};

    logic [63:0] mdl_mem    [2][256];
    int          sweep_left [2];
    logic [63:0] exp_r      [2][4];
    logic        exp_ready  [2];

    stim_t rs [2];
    vec_t  vecs [10];

    rf_multiport u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr0), .ready(ready0),
        .w_ena(wena0), .w_addr(waddr0), .w_data(wdata0), .w_be(wbe0),
        .r_addr(raddr0), .r_data(rdata0)
    );

    rf_multiport #(.DATA_W(8), .ADDR_W(2), .RD_PORTS(4), .ZERO_REG(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr1), .ready(ready1),
        .w_ena(wena1), .w_addr(waddr1), .w_data(wdata1), .w_be(wbe1),
        .r_addr(raddr1), .r_data(rdata1)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dmask(int d);
        return (m_dw[d] == 64) ? '1 : ((64'd1 << m_dw[d]) - 64'd1);
    endfunction

    function automatic logic [63:0] getR(int d, int p);
        if (d == 0) return {32'b0, rdata0[p*32 +: 32]};
        return {56'b0, rdata1[p*8 +: 8]};
    endfunction

    function automatic logic getReady(int d);
        return (d == 0) ? ready0 : ready1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input int d, input stim_t s);
        if (d == 0) begin
            wena0  = s.w_ena;
            waddr0 = s.w_addr[4:0];
            wdata0 = s.w_data[31:0];
            wbe0   = s.w_be[3:0];
            clr0   = s.clr;
            raddr0 = {s.r_addr[1][4:0], s.r_addr[0][4:0]};
        end else begin
            wena1  = s.w_ena;
            waddr1 = s.w_addr[1:0];
            wdata1 = s.w_data[7:0];
            wbe1   = s.w_be[0:0];
            clr1   = s.clr;
            raddr1 = {s.r_addr[3][1:0], s.r_addr[2][1:0], s.r_addr[1][1:0], s.r_addr[0][1:0]};
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: after a reset or clear the file is all zero and unusable for DEPTH edges.
    task automatic modelReset(input int d);
        sweep_left[d] = m_depth[d];
        for (int a = 0; a < 256; a++) mdl_mem[d][a] = '0;
        for (int p = 0; p < 4; p++) exp_r[d][p] = '0;
        exp_ready[d] = 1'b0;
    endtask

    task automatic modelStep(input int d, input stim_t s);
        logic [63:0] v;
        int ra, wa;
        wa = int'(s.w_addr);
        for (int p = 0; p < 4; p++) exp_r[d][p] = '0;
        if (sweep_left[d] > 0) begin
            sweep_left[d]--;
        end else if (s.clr) begin
            modelReset(d);
        end else begin
            for (int p = 0; p < m_np[d]; p++) begin
                ra = int'(s.r_addr[p]);
                v = mdl_mem[d][ra];
                if (s.w_ena && ra == wa)
                    for (int b = 0; b < m_nb[d]; b++)
                        if (s.w_be[b]) v[8*b +: 8] = s.w_data[8*b +: 8];
                if (m_zr[d] != 0 && ra == 0) v = '0;
                exp_r[d][p] = v;
            end
            if (s.w_ena && !(m_zr[d] != 0 && wa == 0))
                for (int b = 0; b < m_nb[d]; b++)
                    if (s.w_be[b]) mdl_mem[d][wa][8*b +: 8] = s.w_data[8*b +: 8];
        end
        exp_ready[d] = (sweep_left[d] == 0);
    endtask

    function automatic stim_t genStim(int d);
        stim_t s;
        logic [31:0] r1, r2;
        int wa;
        s = '0;
        r1 = $urandom;
        s.w_ena = (r1[1:0] != 2'b00);
        s.clr = ($urandom_range(0, 79) == 0);
        wa = r1[2] ? int'($urandom_range(0, 7)) : int'($urandom_range(0, m_depth[d] - 1));
        wa = wa % m_depth[d];
        s.w_addr = 8'(wa);
        r1 = $urandom;
        r2 = $urandom;
        s.w_data = {r1, r2} & dmask(d);
        r1 = $urandom;
        s.w_be = (r1[3:2] == 2'b00) ? 8'hFF : r1[11:4];
        s.w_be = s.w_be & 8'((1 << m_nb[d]) - 1);
        for (int p = 0; p < 4; p++) begin
            r1 = $urandom;
            s.r_addr[p] = (r1[1:0] == 2'b00) ? s.w_addr : 8'($urandom_range(0, m_depth[d] - 1));
        end
        return s;
    endfunction

    task automatic countSweep(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            stepCycle();
            n++;
            if (ready0) break;
        end
    endtask

    // Asynchronous reset: outputs must drop without waiting for a clock edge.
    task automatic applyReset();
        applyStimulus(0, '0);
        applyStimulus(1, '0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ready0", 64'(ready0), 64'd0);
        checkOutput("rst_ready1", 64'(ready1), 64'd0);
        checkOutput("rst_rdata0", rdata0, 64'd0);
        checkOutput("rst_rdata1", 64'(rdata1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset(0);
        modelReset(1);
    endtask

    initial begin
        stim_t s;
        int n;

        vecs[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 4'hF, 1'b0, 5'd5, 5'd7, 1'b1, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd7, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd7, 32'h11223344, 4'h5, 1'b0, 5'd7, 5'd7, 1'b1, 32'hDE22BE44, 32'hDE22BE44};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd7, 5'd3, 1'b1, 32'hDE22BE44, 32'h0};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0,        32'h0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd7, 1'b1, 32'h0,        32'hDE22BE44};
        vecs[6] = '{1'b1, 5'd3, 32'hAAAAAAAA, 4'h0, 1'b0, 5'd3, 5'd3, 1'b1, 32'h0,        32'h0};
        vecs[7] = '{1'b1, 5'd3, 32'hCAFEF00D, 4'hC, 1'b0, 5'd3, 5'd7, 1'b1, 32'hCAFE0000, 32'hDE22BE44};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd3, 5'd3, 1'b1, 32'hCAFE0000, 32'hCAFE0000};
        vecs[9] = '{1'b1, 5'd3, 32'h12345678, 4'hF, 1'b1, 5'd3, 5'd7, 1'b0, 32'h0,        32'h0};

        applyStimulus(0, '0);
        applyStimulus(1, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("init_ready0", 64'(ready0), 64'd0);
        checkOutput("init_rdata0", rdata0, 64'd0);
        rst_n = 1'b1;
        countSweep(n);
        checkOutput("first_sweep_len", 64'(n), 64'd32);

        for (int a = 0; a < 32; a++) begin
            s = '0;
            s.r_addr[0] = 8'(a);
            s.r_addr[1] = 8'(31 - a);
            applyStimulus(0, s);
            stepCycle();
            checkOutput("cleared_p0", getR(0, 0), 64'd0);
            checkOutput("cleared_p1", getR(0, 1), 64'd0);
        end

        for (int i = 0; i < 10; i++) begin
            s = '0;
            s.w_ena = vecs[i].w_ena;
            s.w_addr = {3'b0, vecs[i].w_addr};
            s.w_data = {32'b0, vecs[i].w_data};
            s.w_be = {4'b0, vecs[i].w_be};
            s.clr = vecs[i].clr;
            s.r_addr[0] = {3'b0, vecs[i].ra0};
            s.r_addr[1] = {3'b0, vecs[i].ra1};
            applyStimulus(0, s);
            stepCycle();
            checkOutput($sformatf("vec%0d_ready", i), 64'(ready0), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_p0", i), getR(0, 0), {32'b0, vecs[i].exp0});
            checkOutput($sformatf("vec%0d_p1", i), getR(0, 1), {32'b0, vecs[i].exp1});
        end

        s = '0;
        s.r_addr[0] = 8'd3;
        s.r_addr[1] = 8'd7;
        applyStimulus(0, s);
        countSweep(n);
        checkOutput("clr_sweep_len", 64'(n), 64'd32);
        stepCycle();
        checkOutput("after_clr_addr3", getR(0, 0), 64'd0);
        checkOutput("after_clr_addr7", getR(0, 1), 64'd0);

        s = '0;
        s.clr = 1'b1;
        applyStimulus(0, s);
        stepCycle();
        applyStimulus(0, '0);
        repeat (10) stepCycle();
        checkOutput("mid_sweep_ready", 64'(ready0), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_sweep_rst_ready", 64'(ready0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countSweep(n);
        checkOutput("restart_sweep_len", 64'(n), 64'd32);

        s = '0;
        s.w_ena = 1'b1;
        s.w_data = 64'hFF;
        s.w_be = 8'h01;
        applyStimulus(1, s);
        stepCycle();
        for (int p = 0; p < 4; p++) checkOutput("nozero_bypass", getR(1, p), 64'hFF);
        applyStimulus(1, '0);
        stepCycle();
        checkOutput("nozero_readback", getR(1, 0), 64'hFF);

        applyReset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 500 == 250) applyReset();
            for (int d = 0; d < 2; d++) begin
                rs[d] = genStim(d);
                applyStimulus(d, rs[d]);
                modelStep(d, rs[d]);
            end
            stepCycle();
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("rand_ready_d%0d", d), 64'(getReady(d)), 64'(exp_ready[d]));
                for (int p = 0; p < m_np[d]; p++)
                    checkOutput($sformatf("rand_rdata_d%0d_p%0d", d, p), getR(d, p), exp_r[d][p]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 Parameter DATA_W, default 32: entry width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries; range 1..8.
REQ-003 Parameter RD_PORTS, default 2: number of read ports; range 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, entry 0 reads as zero and ignores writes.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 clr_req  in  1  request a full clear sweep; sampled only while ready=1.
REQ-008 ready  out  1  registered; 1 = RUN state, writes accepted.
REQ-009 w_ena  in  1  write enable.
REQ-010 w_addr  in  ADDR_W  write address.
REQ-011 w_data  in  DATA_W  write data.
REQ-012 w_be  in  DATA_W/8  byte enables; bit i covers w_data[8i+7:8i].
REQ-013 r_addr  in  RD_PORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
REQ-014 r_data  out  RD_PORTS*DATA_W  packed registered read data; port p at [p*DATA_W +: DATA_W].

Function
REQ-015 Two states, CLEAR and RUN, with sweep counter clr_cnt of ADDR_W bits.
REQ-016 In CLEAR, each edge SHALL write zero to entry clr_cnt and increment clr_cnt; the edge writing entry DEPTH-1 SHALL set state RUN and ready=1, and wrap clr_cnt to 0.
REQ-017 In CLEAR, w_ena, w_be and clr_req SHALL be ignored; every r_data port SHALL load zero each edge.
REQ-018 In RUN, an edge with clr_req=1 SHALL enter CLEAR with clr_cnt=0 and ready=0; a w_ena on that same edge SHALL be dropped; r_data SHALL load zero on that edge.
REQ-019 In RUN, with w_ena=1 and clr_req=0, each byte i with w_be[i]=1 SHALL be written to entry w_addr; bytes with w_be[i]=0 retain their value; w_be all-zero is a no-op.
REQ-020 With ZERO_REG=1, writes to address 0 SHALL be discarded and every port reading address 0 SHALL load zero.
REQ-021 In RUN, each port p SHALL load r_data on every edge: read latency exactly 1 cycle, no read enable.
REQ-022 Write-through bypass: if w_ena=1 (write accepted) and r_addr[p]==w_addr, port p SHALL load w_data bytes where w_be=1 and pre-write stored bytes where w_be=0; ZERO_REG rule of REQ-020 overrides the bypass.
REQ-023 All ports operate independently; any number of ports may read the same address, including the address being written, in the same cycle.
REQ-024 Write and bypass decisions SHALL use only values sampled at the current edge; no combinational path from inputs to r_data or ready.

Reset
REQ-025 rst_n low SHALL immediately force state CLEAR, clr_cnt=0, ready=0, all r_data=0; storage contents are not reset directly.
REQ-026 On the first rising edge with rst_n high the sweep SHALL begin at entry 0; ready SHALL read 1 after exactly DEPTH rising edges.
REQ-027 rst_n asserted mid-sweep or mid-RUN SHALL restart the full sweep from entry 0 after release.

Verification
REQ-028 Defaults; release rst_n, count edges -> ready=0 for edges 1..31, ready=1 after edge 32; read all 32 addresses on both ports -> all 0x00000000.
REQ-029 Write 0xDEADBEEF to addr 7 with w_be=4'hF, next cycle r_addr0=7 -> r_data0=0x00000000 until edge after write-back read, then 0xDEADBEEF; same-edge read of addr 7 on port 1 during the write -> 0xDEADBEEF (bypass).
REQ-030 Addr 7 holds 0xDEADBEEF; write 0x11223344 with w_be=4'b0101 while port 0 reads 7 -> r_data0=0xDE22BE44, later reads also 0xDE22BE44.
REQ-031 ZERO_REG=1: write 0xFFFFFFFF to addr 0 while port 1 reads 0 -> r_data1=0, later reads of 0 return 0; ZERO_REG=0 same stimulus -> 0xFFFFFFFF.
REQ-032 In RUN, assert clr_req with w_ena to addr 3 on same edge -> ready=0 for 32 edges, write dropped, afterwards addr 3 and previously written addr 7 read 0; assert rst_n low at edge 10 of the sweep -> ready returns 1 exactly 32 edges after release.
REQ-033 Sweep RD_PORTS=1..4, ADDR_W=2 and 5, DATA_W=8 and 32 with random traffic against a byte-enable-aware reference model -> zero mismatches.
